ddmtd_lock_detect: RTL and testbench
====================================

Name: ddmtd_lock_detect

Overview:
Downstream consumer of the DDMTD sampler's phase_valid/phase_err_beat stream, in parallel with the loop filter. It judges loop lock with a hysteresis state machine and detects loss of beat samples (timeout). It also produces windowed phase-error statistics (mean, peak |err|) for debug outputs and for firmware/pin readout.

Parameters:
ERR_W, 16, width of signed phase error input
LOCK_THR, 64, max |err| counted as a good sample (inclusive)
LOCK_CNT, 16, consecutive good samples needed to declare lock (>=1)
UNLOCK_CNT, 4, consecutive bad samples that drop lock (>=1)
TIMEOUT, 65535, clk cycles without phase_valid that count as sample loss (>=2)
WIN_LOG2, 4, statistics window = 2^WIN_LOG2 valid samples

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ena  in  1  global enable; low freezes all state
phase_valid  in  1  one-cycle strobe, phase_err valid
phase_err  in  ERR_W  signed phase error per beat
lock_state  out  2  0 UNLOCKED, 1 ACQUIRE, 2 LOCKED, 3 HOLDOVER
locked  out  1  high in LOCKED or HOLDOVER
lost_pulse  out  1  one-cycle strobe on LOCKED/HOLDOVER -> UNLOCKED
timeout  out  1  level, high while the no-sample counter is saturated
stats_valid  out  1  one-cycle strobe, new window statistics
err_avg  out  ERR_W  signed window mean
err_peak  out  ERR_W-1  max |err| in window

Behaviour:
- Reset: state UNLOCKED. All counters, outputs and stats registers 0.
- Reset is asynchronous and may occur mid-window or mid-state: everything returns to reset values, and the partial window is discarded.
- ena=0: no register changes; strobes deassert; phase_valid is ignored.
- abs(err): magnitude, with -2^(ERR_W-1) saturating to 2^(ERR_W-1)-1. good = abs<=LOCK_THR; bad otherwise.
- All outputs are registered. State and lost_pulse update on the cycle after the phase_valid sample is seen.
- Sample counter sc: increments on cycles without phase_valid and saturates at TIMEOUT. A phase_valid sample clears it.
- Timeout event: sc reaches TIMEOUT. timeout=1 while sc==TIMEOUT.
- If phase_valid and the expiry coincide, the sample wins: no timeout event, sc cleared.
- FSM (gc = good counter, bc = bad counter):
  UNLOCKED: good -> ACQUIRE, gc=1 (if LOCK_CNT==1 -> LOCKED directly). bad -> stay, gc=0.
  ACQUIRE: good -> gc++; when gc==LOCK_CNT -> LOCKED, bc=0. bad -> UNLOCKED, gc=0. timeout event -> UNLOCKED.
  LOCKED: good -> bc=0. bad -> bc++; when bc==UNLOCK_CNT -> UNLOCKED, lost_pulse. timeout event -> HOLDOVER.
  HOLDOVER: good -> LOCKED, bc=0. bad -> UNLOCKED, lost_pulse. Stays indefinitely without samples.
- Stats: each valid sample adds sign-extended err to sum (ERR_W+WIN_LOG2 bits) and updates peak=max(peak,abs).
- On the 2^WIN_LOG2-th sample: err_avg <= (sum+err)>>>WIN_LOG2 (arithmetic, floor), err_peak <= max(peak,abs), stats_valid=1 next cycle. sum, peak and the window count then clear.
- err_avg/err_peak hold between windows. Stats run independently of the FSM and of timeouts.

Decomposition:
- Shared package ddmtd_pkg: lock-state encodings (ST_UNLOCKED..ST_HOLDOVER) and the default ERR_W. The loop filter and top debug mux reuse these.
- One sub-module, ddmtd_abs_sat (parameter W): combinational saturating magnitude. It is reused by later peak/threshold logic.
- Counters (gc, bc, sc, window count) are sized with $clog2 of their limits, plus 1.

Test Plan:
1. LOCK_CNT=4, THR=64: 4 valid samples err=+10, -64, 0, +64 -> lock_state 1,1,1,2. locked=1 one cycle after the 4th strobe.
2. Locked, UNLOCK_CNT=4: err=65, 65, 3, 65, 65, 65, 65 -> bc resets on the 3; lost_pulse single cycle after the 7th sample, state 0.
3. TIMEOUT=100, locked, strobes stop -> state 3 and timeout=1 at cycle 100. Then err=5 -> state 2, timeout=0. Repeat with err=500 -> state 0 + lost_pulse.
4. WIN_LOG2=2: errs -3, -2, 7, 1 -> stats_valid once, err_avg=0 (3>>>2), err_peak=7. Next window errs -8, -8, -8, -9 -> err_avg=-9 (floor of -8.25), err_peak=9.
5. err=-32768 (ERR_W=16) -> abs=32767: counted bad, err_peak=32767, no overflow in sum.
6. ena=0 while strobing good samples -> no state/stat change. rst_n low mid-window in LOCKED -> all outputs 0 immediately (asynchronous). The next window starts fresh.

Source files
------------

// File: rtl/ddmtd_pkg.sv
// Shared DDMTD definitions: lock-state encodings and default phase-error width.
package ddmtd_pkg;

    localparam int unsigned DEF_ERR_W = 16;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_LOCKED   = 2'd2,
        ST_HOLDOVER = 2'd3
    } lock_state_e;

endpackage

// File: rtl/ddmtd_abs_sat.sv
// Saturating magnitude of a signed W-bit value: the most negative input maps to 2^(W-1)-1.
module ddmtd_abs_sat #(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0] a,
    output logic [W-2:0] mag
);

    always_comb begin
        if (!a[W-1]) begin
            mag = a[W-2:0];
        end else if (a[W-2:0] == '0) begin
            mag = '1;
        end else begin
            // Low bits of the two's-complement negation.
            mag = ~a[W-2:0] + 1'b1;
        end
    end

endmodule

// File: rtl/ddmtd_lock_detect.sv
// Lock judgement (hysteresis FSM), beat-sample loss timeout and windowed phase-error
// statistics for the DDMTD phase_valid/phase_err stream.
module ddmtd_lock_detect
    import ddmtd_pkg::*;
#(
    parameter int unsigned ERR_W      = DEF_ERR_W,
    parameter int unsigned LOCK_THR   = 64,
    parameter int unsigned LOCK_CNT   = 16,
    parameter int unsigned UNLOCK_CNT = 4,
    parameter int unsigned TIMEOUT    = 65535,
    parameter int unsigned WIN_LOG2   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ena,
    input  logic                    phase_valid,
    input  logic signed [ERR_W-1:0] phase_err,
    output logic [1:0]              lock_state,
    output logic                    locked,
    output logic                    lost_pulse,
    output logic                    timeout,
    output logic                    stats_valid,
    output logic signed [ERR_W-1:0] err_avg,
    output logic [ERR_W-2:0]        err_peak
);

    localparam int unsigned GC_W  = $clog2(LOCK_CNT) + 1;
    localparam int unsigned BC_W  = $clog2(UNLOCK_CNT) + 1;
    localparam int unsigned SC_W  = $clog2(TIMEOUT) + 1;
    localparam int unsigned WC_W  = WIN_LOG2 + 1;
    localparam int unsigned SUM_W = ERR_W + WIN_LOG2;
    localparam int unsigned MAG_W = ERR_W - 1;

    localparam logic [GC_W-1:0] GC_LIM  = GC_W'(LOCK_CNT);
    localparam logic [BC_W-1:0] BC_LIM  = BC_W'(UNLOCK_CNT);
    localparam logic [SC_W-1:0] SC_LIM  = SC_W'(TIMEOUT);
    localparam logic [SC_W-1:0] SC_PRE  = SC_W'(TIMEOUT - 1);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(2 ** WIN_LOG2 - 1);

    lock_state_e      state_q;
    logic [GC_W-1:0]  gc_q;
    logic [BC_W-1:0]  bc_q;
    logic             lost_q;
    logic [SC_W-1:0]  sc_q, sc_d;
    logic             timeout_q;
    logic [MAG_W-1:0] mag;
    logic             good;
    logic             sample;
    logic             tmo_evt;

    ddmtd_abs_sat #(
        .W (ERR_W)
    ) u_abs_sat (
        .a   (phase_err),
        .mag (mag)
    );

    assign good    = 32'(mag) <= LOCK_THR;
    assign sample  = ena & phase_valid;
    // A sample arriving on the expiry cycle suppresses the timeout event.
    assign tmo_evt = ena & ~phase_valid & (sc_q == SC_PRE);

    always_comb begin
        sc_d = sc_q;
        if (phase_valid) begin
            sc_d = '0;
        end else if (sc_q != SC_LIM) begin
            sc_d = sc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sc_q      <= '0;
            timeout_q <= 1'b0;
        end else if (ena) begin
            sc_q      <= sc_d;
            timeout_q <= (sc_d == SC_LIM);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_UNLOCKED;
            gc_q    <= '0;
            bc_q    <= '0;
            lost_q  <= 1'b0;
        end else begin
            lost_q <= 1'b0;
            if (sample) begin
                unique case (state_q)
                    ST_UNLOCKED: begin
                        if (!good) begin
                            gc_q <= '0;
                        end else if (LOCK_CNT == 1) begin
                            state_q <= ST_LOCKED;
                            gc_q    <= '0;
                            bc_q    <= '0;
                        end else begin
                            state_q <= ST_ACQUIRE;
                            gc_q    <= GC_W'(1);
                        end
                    end
                    ST_ACQUIRE: begin
                        if (!good) begin
                            state_q <= ST_UNLOCKED;
                            gc_q    <= '0;
                        end else if (gc_q + 1'b1 == GC_LIM) begin
                            state_q <= ST_LOCKED;
                            gc_q    <= '0;
                            bc_q    <= '0;
                        end else begin
                            gc_q <= gc_q + 1'b1;
                        end
                    end
                    ST_LOCKED: begin
                        if (good) begin
                            bc_q <= '0;
                        end else if (bc_q + 1'b1 == BC_LIM) begin
                            state_q <= ST_UNLOCKED;
                            bc_q    <= '0;
                            gc_q    <= '0;
                            lost_q  <= 1'b1;
                        end else begin
                            bc_q <= bc_q + 1'b1;
                        end
                    end
                    ST_HOLDOVER: begin
                        bc_q <= '0;
                        if (good) begin
                            state_q <= ST_LOCKED;
                        end else begin
                            state_q <= ST_UNLOCKED;
                            gc_q    <= '0;
                            lost_q  <= 1'b1;
                        end
                    end
                endcase
            end else if (tmo_evt) begin
                if (state_q == ST_ACQUIRE) begin
                    state_q <= ST_UNLOCKED;
                    gc_q    <= '0;
                end else if (state_q == ST_LOCKED) begin
                    state_q <= ST_HOLDOVER;
                end
            end
        end
    end

    logic [SUM_W-1:0] sum_q, sum_nx;
    logic [MAG_W-1:0] peak_q, peak_nx;
    logic [WC_W-1:0]  wc_q;
    logic             stats_valid_q;
    logic [ERR_W-1:0] avg_q;
    logic [MAG_W-1:0] peak_out_q;

    always_comb begin
        sum_nx  = sum_q + {{WIN_LOG2{phase_err[ERR_W-1]}}, phase_err};
        peak_nx = (mag > peak_q) ? mag : peak_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q         <= '0;
            peak_q        <= '0;
            wc_q          <= '0;
            stats_valid_q <= 1'b0;
            avg_q         <= '0;
            peak_out_q    <= '0;
        end else begin
            stats_valid_q <= 1'b0;
            if (sample) begin
                if (wc_q == WC_LAST) begin
                    // Dropping the low WIN_LOG2 bits is a flooring arithmetic shift.
                    avg_q         <= sum_nx[SUM_W-1:WIN_LOG2];
                    peak_out_q    <= peak_nx;
                    stats_valid_q <= 1'b1;
                    sum_q         <= '0;
                    peak_q        <= '0;
                    wc_q          <= '0;
                end else begin
                    sum_q  <= sum_nx;
                    peak_q <= peak_nx;
                    wc_q   <= wc_q + 1'b1;
                end
            end
        end
    end

    assign lock_state  = state_q;
    // LOCKED and HOLDOVER are the only encodings with bit 1 set.
    assign locked      = state_q[1];
    assign lost_pulse  = lost_q;
    assign timeout     = timeout_q;
    assign stats_valid = stats_valid_q;
    assign err_avg     = avg_q;
    assign err_peak    = peak_out_q;

endmodule

// File: tb/tb_ddmtd_lock_detect.sv
// Directed bench for ddmtd_lock_detect: lock FSM, timeout and window statistics,
// with window results predicted by a small reference model and queued per window.
module tb_ddmtd_lock_detect;
    import ddmtd_pkg::*;

    localparam int ERR_W      = 16;
    localparam int LOCK_THR   = 64;
    localparam int LOCK_CNT   = 4;
    localparam int UNLOCK_CNT = 4;
    localparam int TIMEOUT    = 100;
    localparam int WIN_LOG2   = 2;
    localparam int WIN        = 1 << WIN_LOG2;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    ena = 1'b0;
    logic                    phase_valid = 1'b0;
    logic signed [ERR_W-1:0] phase_err = '0;
    logic [1:0]              lock_state;
    logic                    locked;
    logic                    lost_pulse;
    logic                    timeout;
    logic                    stats_valid;
    logic signed [ERR_W-1:0] err_avg;
    logic [ERR_W-2:0]        err_peak;

    ddmtd_lock_detect #(
        .ERR_W      (ERR_W),
        .LOCK_THR   (LOCK_THR),
        .LOCK_CNT   (LOCK_CNT),
        .UNLOCK_CNT (UNLOCK_CNT),
        .TIMEOUT    (TIMEOUT),
        .WIN_LOG2   (WIN_LOG2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .phase_valid (phase_valid),
        .phase_err   (phase_err),
        .lock_state  (lock_state),
        .locked      (locked),
        .lost_pulse  (lost_pulse),
        .timeout     (timeout),
        .stats_valid (stats_valid),
        .err_avg     (err_avg),
        .err_peak    (err_peak)
    );

    always #5 clk = ~clk;

    typedef struct {
        int avg;
        int peak;
    } stat_t;

    stat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    m_sum  = 0;
    int    m_peak = 0;
    int    m_cnt  = 0;

    function automatic int abs_sat(int e);
        if (e == -(1 << (ERR_W - 1))) return (1 << (ERR_W - 1)) - 1;
        return (e < 0) ? -e : e;
    endfunction

    function automatic int floor_div(int s, int d);
        int q;
        q = s / d;
        if ((s % d) != 0 && s < 0) q = q - 1;
        return q;
    endfunction

    task automatic chk(string tag, int got, int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_sum  = 0;
        m_peak = 0;
        m_cnt  = 0;
        exp_q.delete();
    endtask

    task automatic sample(int e, int exp_st, int exp_lost);
        bit    win_done;
        stat_t s;
        win_done = 1'b0;
        @(negedge clk);
        phase_valid = 1'b1;
        phase_err   = ERR_W'(e);
        if (ena) begin
            m_sum = m_sum + e;
            if (abs_sat(e) > m_peak) m_peak = abs_sat(e);
            m_cnt++;
            if (m_cnt == WIN) begin
                s.avg  = floor_div(m_sum, WIN);
                s.peak = m_peak;
                exp_q.push_back(s);
                win_done = 1'b1;
                m_sum  = 0;
                m_peak = 0;
                m_cnt  = 0;
            end
        end
        @(posedge clk);
        #1;
        phase_valid = 1'b0;
        chk("lock_state", int'(lock_state), exp_st);
        chk("locked", int'(locked), (exp_st >= 2) ? 1 : 0);
        chk("lost_pulse", int'(lost_pulse), exp_lost);
        chk("stats_valid", int'(stats_valid), int'(win_done));
        if ((win_done || stats_valid) && exp_q.size() > 0) begin
            s = exp_q.pop_front();
            chk("err_avg", int'(err_avg), s.avg);
            chk("err_peak", int'(err_peak), s.peak);
        end
    endtask

    task automatic idle(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(string tag);
        chk({tag, "_state"}, int'(lock_state), 0);
        chk({tag, "_locked"}, int'(locked), 0);
        chk({tag, "_lost"}, int'(lost_pulse), 0);
        chk({tag, "_timeout"}, int'(timeout), 0);
        chk({tag, "_stats_valid"}, int'(stats_valid), 0);
        chk({tag, "_avg"}, int'(err_avg), 0);
        chk({tag, "_peak"}, int'(err_peak), 0);
    endtask

    initial begin
        ena = 1'b1;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Acquire with boundary-good samples (|err| == LOCK_THR).
        sample(10, int'(ST_ACQUIRE), 0);
        sample(-64, int'(ST_ACQUIRE), 0);
        sample(0, int'(ST_ACQUIRE), 0);
        sample(64, int'(ST_LOCKED), 0);

        // Bad run interrupted by a good sample, then four bad drop lock.
        sample(65, int'(ST_LOCKED), 0);
        sample(65, int'(ST_LOCKED), 0);
        sample(3, int'(ST_LOCKED), 0);
        sample(65, int'(ST_LOCKED), 0);
        sample(65, int'(ST_LOCKED), 0);
        sample(65, int'(ST_LOCKED), 0);
        sample(65, int'(ST_UNLOCKED), 1);
        idle(1);
        chk("lost_single_cycle", int'(lost_pulse), 0);
        chk("unlocked_after_loss", int'(lock_state), int'(ST_UNLOCKED));

        // Timeout into HOLDOVER and recovery.
        sample(5, int'(ST_ACQUIRE), 0);
        sample(5, int'(ST_ACQUIRE), 0);
        sample(5, int'(ST_ACQUIRE), 0);
        sample(5, int'(ST_LOCKED), 0);
        idle(TIMEOUT - 1);
        chk("pre_timeout_state", int'(lock_state), int'(ST_LOCKED));
        chk("pre_timeout_flag", int'(timeout), 0);
        idle(1);
        chk("timeout_state", int'(lock_state), int'(ST_HOLDOVER));
        chk("timeout_flag", int'(timeout), 1);
        chk("holdover_locked", int'(locked), 1);
        idle(20);
        chk("holdover_stays", int'(lock_state), int'(ST_HOLDOVER));
        chk("timeout_saturated", int'(timeout), 1);
        sample(5, int'(ST_LOCKED), 0);
        chk("timeout_cleared", int'(timeout), 0);
        idle(TIMEOUT);
        chk("timeout2_state", int'(lock_state), int'(ST_HOLDOVER));
        chk("timeout2_flag", int'(timeout), 1);
        sample(500, int'(ST_UNLOCKED), 1);
        chk("timeout2_cleared", int'(timeout), 0);

        // Timeout while acquiring returns to UNLOCKED.
        sample(5, int'(ST_ACQUIRE), 0);
        idle(TIMEOUT);
        chk("acq_timeout_state", int'(lock_state), int'(ST_UNLOCKED));
        chk("acq_timeout_flag", int'(timeout), 1);

        // Sample coinciding with the expiry cycle wins.
        sample(5, int'(ST_ACQUIRE), 0);
        sample(5, int'(ST_ACQUIRE), 0);
        sample(5, int'(ST_ACQUIRE), 0);
        sample(5, int'(ST_LOCKED), 0);
        idle(TIMEOUT - 1);
        sample(5, int'(ST_LOCKED), 0);
        chk("coincide_no_timeout", int'(timeout), 0);

        // ena low freezes everything, even against a run of bad samples.
        ena = 1'b0;
        sample(500, int'(ST_LOCKED), 0);
        sample(500, int'(ST_LOCKED), 0);
        sample(500, int'(ST_LOCKED), 0);
        sample(500, int'(ST_LOCKED), 0);
        idle(TIMEOUT + 5);
        chk("ena_low_state", int'(lock_state), int'(ST_LOCKED));
        chk("ena_low_timeout", int'(timeout), 0);
        ena = 1'b1;
        sample(500, int'(ST_LOCKED), 0);

        // Asynchronous reset mid-window while LOCKED.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;

        // Fresh windows: floor rounding for positive and negative sums.
        sample(-3, int'(ST_ACQUIRE), 0);
        sample(-2, int'(ST_ACQUIRE), 0);
        sample(7, int'(ST_ACQUIRE), 0);
        sample(1, int'(ST_LOCKED), 0);
        sample(-8, int'(ST_LOCKED), 0);
        sample(-8, int'(ST_LOCKED), 0);
        sample(-8, int'(ST_LOCKED), 0);
        sample(-9, int'(ST_LOCKED), 0);
        idle(3);
        chk("avg_holds", int'(err_avg), -9);
        chk("peak_holds", int'(err_peak), 9);
        chk("no_extra_stats", int'(stats_valid), 0);

        // Most negative error: bad, saturating magnitude, no sum overflow.
        sample(-32768, int'(ST_LOCKED), 0);
        sample(-32768, int'(ST_LOCKED), 0);
        sample(-32768, int'(ST_LOCKED), 0);
        sample(-32768, int'(ST_UNLOCKED), 1);
        chk("min_err_avg", int'(err_avg), -32768);
        chk("min_err_peak", int'(err_peak), 32767);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
